// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit counters and optional RAS.
// Define BPRED_RAS_EN to build in the return-address stack.
module branch_predictor #(
    parameter int ENTRIES   = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [1:0]  upd_type,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic [4:0]  upd_rd,
    input  logic [4:0]  upd_rs1
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = 30 - IDX;

    typedef enum logic [1:0] {
        K_BR  = 2'd0,
        K_JMP = 2'd1,
        K_RET = 2'd2
    } kind_e;

    logic [ENTRIES-1:0] v_q;
    logic [TW-1:0]      tag_q  [ENTRIES];
    logic [31:0]        tgt_q  [ENTRIES];
    kind_e              kind_q [ENTRIES];
    logic [1:0]         ctr_q  [ENTRIES];

    // ---------------- lookup ----------------
    logic [IDX-1:0] l_idx;
    logic [TW-1:0]  l_tag;
    logic           l_hit;
    logic [31:0]    l_seq;
    logic [31:0]    ret_tgt;

    assign l_idx = pc_if[IDX+1:2];
    assign l_tag = pc_if[31:IDX+2];
    assign l_hit = v_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_seq = pc_if + 32'd4;

    // ---------------- update decode ----------------
    logic [IDX-1:0] u_idx;
    logic [TW-1:0]  u_tag;
    logic           u_hit;
    logic           act;
    logic           is_jump;
    logic           is_jalr;
    logic           rs1_link;
    logic           is_ret;
    kind_e          u_kind;
    logic           alloc;
    logic           wr;
    logic [1:0]     ctr_sat;
    logic [1:0]     ctr_wr;
    logic           unused_bits;

    assign u_idx    = upd_pc[IDX+1:2];
    assign u_tag    = upd_pc[31:IDX+2];
    assign u_hit    = v_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign act      = upd_valid && (upd_type != 2'b00);
    assign is_jump  = upd_type[1];
    assign is_jalr  = (upd_type == 2'b11);
    assign rs1_link = (upd_rs1 == 5'd1) || (upd_rs1 == 5'd5);
    assign is_ret   = is_jalr && (upd_rd == 5'd0) && rs1_link;
    assign alloc    = !u_hit && (is_jump || upd_taken);
    assign wr       = act && (u_hit || alloc);
    assign ctr_wr   = u_hit ? ctr_sat : 2'b10;

    assign unused_bits = ^{pc_if[1:0], upd_pc[1:0]};

    // Kind of the resolved instruction as stored in the BTB.
    always_comb begin
        u_kind = K_BR;
        if (is_ret)
            u_kind = K_RET;
        else if (is_jump)
            u_kind = K_JMP;
    end

    // Saturating 2-bit counter step toward the resolved direction.
    always_comb begin
        ctr_sat = ctr_q[u_idx];
        if (upd_taken) begin
            if (ctr_q[u_idx] != 2'b11)
                ctr_sat = ctr_q[u_idx] + 2'b01;
        end else begin
            if (ctr_q[u_idx] != 2'b00)
                ctr_sat = ctr_q[u_idx] - 2'b01;
        end
    end

    // ---------------- return-address stack ----------------
`ifdef BPRED_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_top;
    logic [CW-1:0] ras_cnt;
    logic [PW-1:0] top_inc;
    logic [PW-1:0] top_dec;
    logic [31:0]   upd_seq;
    logic          rd_link;
    logic          push;
    logic          pop;

    assign upd_seq = upd_pc + 32'd4;
    assign rd_link = (upd_rd == 5'd1) || (upd_rd == 5'd5);
    assign push    = act && is_jump && rd_link;
    assign pop     = act && (is_ret ||
                     (is_jalr && rd_link && rs1_link && (upd_rd != upd_rs1)));
    assign top_inc = (ras_top == PW'(RAS_DEPTH - 1)) ? '0 : ras_top + 1'b1;
    assign top_dec = (ras_top == '0) ? PW'(RAS_DEPTH - 1) : ras_top - 1'b1;
    assign ret_tgt = (ras_cnt != '0) ? ras_mem[ras_top] : tgt_q[l_idx];

    // Circular stack: full pushes overwrite the oldest slot, empty pops are no-ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_cnt <= '0;
            ras_top <= '0;
        end else begin
            case ({push, pop})
                2'b11: ras_mem[ras_top] <= upd_seq;
                2'b10: begin
                    ras_top          <= top_inc;
                    ras_mem[top_inc] <= upd_seq;
                    if (ras_cnt != CW'(RAS_DEPTH))
                        ras_cnt <= ras_cnt + 1'b1;
                end
                2'b01: begin
                    if (ras_cnt != '0) begin
                        ras_top <= top_dec;
                        ras_cnt <= ras_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign ret_tgt = tgt_q[l_idx];
`endif

    // Prediction from current table state; same-cycle updates are not forwarded.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = l_seq;
        if (l_hit) begin
            case (kind_q[l_idx])
                K_BR:    pred_taken = ctr_q[l_idx][1];
                default: pred_taken = 1'b1;
            endcase
        end
        if (pred_taken)
            pred_target = (kind_q[l_idx] == K_RET) ? ret_tgt : tgt_q[l_idx];
    end

    // Valid bits and counters: cleared on reset, written on hit or allocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_q[i] <= 2'b01;
        end else if (wr) begin
            v_q[u_idx]   <= 1'b1;
            ctr_q[u_idx] <= ctr_wr;
        end
    end

    // Tag, target and kind payload; no reset needed since valid gates it.
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            tag_q[u_idx]  <= u_tag;
            tgt_q[u_idx]  <= upd_target;
            kind_q[u_idx] <= u_kind;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, RAS_DEPTH=4).
// RAS checks are built only when BPRED_RAS_EN is defined.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [4:0]  upd_rd;
    logic [4:0]  upd_rs1;

    int n_run;
    int n_fail;

    branch_predictor #(.ENTRIES(16), .RAS_DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_if       (pc_if),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_type    (upd_type),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_rd      (upd_rd),
        .upd_rs1     (upd_rs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic [1:0] ty,
                       input logic tk, input logic [31:0] tg,
                       input logic [4:0] rd, input logic [4:0] rs1);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_type   = ty;
        upd_taken  = tk;
        upd_target = tg;
        upd_rd     = rd;
        upd_rs1    = rs1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_type  = 2'b00;
    endtask

    task automatic look(input string nm, input logic [31:0] pc,
                        input logic etk, input logic [31:0] etg);
        pc_if = pc;
        #1;
        check({nm, ".taken"}, {31'd0, pred_taken}, {31'd0, etk});
        check({nm, ".target"}, pred_target, etg);
    endtask

    initial begin
        logic [31:0] pops [4];
        n_run      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        pc_if      = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_type   = 2'b00;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        upd_rd     = 5'd0;
        upd_rs1    = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        look("reset", 32'h100, 1'b0, 32'h104);

        upd(32'h100, 2'b01, 1'b1, 32'h80, 5'd0, 5'd0);
        look("br_alloc", 32'h100, 1'b1, 32'h80);

        upd(32'h100, 2'b01, 1'b0, 32'h80, 5'd0, 5'd0);
        upd(32'h100, 2'b01, 1'b0, 32'h80, 5'd0, 5'd0);
        look("br_weak_nt", 32'h100, 1'b0, 32'h104);

        repeat (3) upd(32'h100, 2'b01, 1'b1, 32'h80, 5'd0, 5'd0);
        upd(32'h100, 2'b01, 1'b0, 32'h80, 5'd0, 5'd0);
        look("br_hyst", 32'h100, 1'b1, 32'h80);

        upd(32'h200, 2'b01, 1'b0, 32'h900, 5'd0, 5'd0);
        look("nt_noalloc", 32'h200, 1'b0, 32'h204);

        upd(32'h40, 2'b10, 1'b1, 32'h1000, 5'd0, 5'd0);
        upd(32'h80, 2'b10, 1'b1, 32'h2000, 5'd0, 5'd0);
        look("alias_old", 32'h40, 1'b0, 32'h44);
        look("alias_new", 32'h80, 1'b1, 32'h2000);

        upd_valid  = 1'b1;
        upd_pc     = 32'h604;
        upd_type   = 2'b10;
        upd_taken  = 1'b1;
        upd_target = 32'h3000;
        upd_rd     = 5'd0;
        upd_rs1    = 5'd0;
        look("same_cyc_old", 32'h604, 1'b0, 32'h608);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_type  = 2'b00;
        look("same_cyc_new", 32'h604, 1'b1, 32'h3000);

        upd_valid  = 1'b1;
        upd_pc     = 32'h608;
        upd_type   = 2'b10;
        upd_target = 32'h4000;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        upd_valid = 1'b0;
        upd_type  = 2'b00;
        look("rst_drop", 32'h608, 1'b0, 32'h60c);
        look("rst_clr", 32'h80, 1'b0, 32'h84);

        upd(32'h300, 2'b10, 1'b1, 32'h900, 5'd1, 5'd0);
        upd(32'h504, 2'b11, 1'b1, 32'h304, 5'd0, 5'd1);
        upd(32'h408, 2'b10, 1'b1, 32'h900, 5'd1, 5'd0);
`ifdef BPRED_RAS_EN
        look("ret_ras", 32'h504, 1'b1, 32'h40c);

        upd(32'h700, 2'b10, 1'b1, 32'h900, 5'd1, 5'd0);
        upd(32'h710, 2'b10, 1'b1, 32'h900, 5'd5, 5'd0);
        upd(32'h720, 2'b10, 1'b1, 32'h900, 5'd1, 5'd0);
        upd(32'h730, 2'b11, 1'b1, 32'h900, 5'd5, 5'd0);
        upd(32'h740, 2'b10, 1'b1, 32'h900, 5'd1, 5'd0);
        look("ras_full", 32'h504, 1'b1, 32'h744);

        upd(32'h800, 2'b11, 1'b1, 32'h900, 5'd1, 5'd5);
        look("ras_pushpop", 32'h504, 1'b1, 32'h804);

        pops[0] = 32'h734;
        pops[1] = 32'h724;
        pops[2] = 32'h714;
        pops[3] = 32'h304;
        for (int i = 0; i < 4; i++) begin
            upd(32'h504, 2'b11, 1'b1, 32'h304, 5'd0, 5'd1);
            look($sformatf("ras_pop%0d", i), 32'h504, 1'b1, pops[i]);
        end
`else
        pops[0] = 32'h304;
        look("ret_btb", 32'h504, 1'b1, pops[0]);
        upd(32'h800, 2'b11, 1'b1, 32'h900, 5'd1, 5'd5);
        look("ret_btb_keep", 32'h504, 1'b1, pops[0]);
`endif

        look("jmp_hit", 32'h408, 1'b1, 32'h900);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
